// File: rtl/pll_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_seq
// Description : Hardware sequencer for the pixel-clock PLL serial config port.
//               One start pulse holds the PLL in reset, shifts the config word
//               out MSB first on SCLK/SDI, releases the PLL, waits for a stable
//               synchronised lock (or a timeout) and then drops the
//               pixel-domain reset request.
//               Optional feature macro: PLL_CFG_READBACK_EN
//                 defined   -> SDO is captured into readback and compared with
//                              the latched config word (verify_err).
//                 undefined -> readback and verify_err are constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_cfg_seq #(
  parameter int CFG_BITS     = 26,
  parameter int CLK_DIV      = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                start,
  input  logic [CFG_BITS-1:0] cfg_data,
  input  logic                pll_sdo,
  input  logic                pll_locked,
  output logic                pll_sclk,
  output logic                pll_sdi,
  output logic                pll_nreset,
  output logic                pclk_reset_req,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [CFG_BITS-1:0] readback,
  output logic                verify_err
);

  localparam int HOLD_W   = $clog2(RST_CYCLES) + 1;
  localparam int DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int BIT_W    = $clog2(CFG_BITS) + 1;
  localparam int STABLE_W = $clog2(LOCK_STABLE) + 1;
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_TOP    = BIT_W'(CFG_BITS - 1);
  localparam logic [STABLE_W-1:0] STABLE_TGT = STABLE_W'(LOCK_STABLE);
  localparam logic [TMO_W-1:0]    TMO_TGT    = TMO_W'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_SHIFT_LO  = 3'd2,
    S_SHIFT_HI  = 3'd3,
    S_RELEASE   = 3'd4,
    S_WAIT_LOCK = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
  logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_idx_nxt;
  logic [STABLE_W-1:0]   stable_cnt, stable_cnt_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic [CFG_BITS-1:0]   shreg, shreg_nxt;
  logic                  lock_ok, lock_ok_nxt;
  logic                  sclk_q, sclk_nxt;
  logic                  sdi_q, sdi_nxt;
  logic                  nrst_q, nrst_nxt;
  logic                  preq_q, preq_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  terr_q, terr_nxt;

  logic                  lock_meta;
  logic                  locked_s;

`ifdef PLL_CFG_READBACK_EN
  logic [CFG_BITS-1:0]   cfg_lat, cfg_lat_nxt;
  logic [CFG_BITS-1:0]   rb_q, rb_nxt;
  logic                  verr_q, verr_nxt;
`else
  // SDO is intentionally ignored when readback is compiled out
  logic                  unused_sdo;
  assign unused_sdo = pll_sdo;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      lock_ok    <= 1'b0;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      nrst_q     <= 1'b0;
      preq_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
`ifdef PLL_CFG_READBACK_EN
      cfg_lat    <= '0;
      rb_q       <= '0;
      verr_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      stable_cnt <= stable_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      shreg      <= shreg_nxt;
      lock_ok    <= lock_ok_nxt;
      sclk_q     <= sclk_nxt;
      sdi_q      <= sdi_nxt;
      nrst_q     <= nrst_nxt;
      preq_q     <= preq_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      terr_q     <= terr_nxt;
`ifdef PLL_CFG_READBACK_EN
      cfg_lat    <= cfg_lat_nxt;
      rb_q       <= rb_nxt;
      verr_q     <= verr_nxt;
`endif
    end
  end

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    div_cnt_nxt    = div_cnt;
    bit_idx_nxt    = bit_idx;
    stable_cnt_nxt = stable_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    shreg_nxt      = shreg;
    lock_ok_nxt    = lock_ok;
    sclk_nxt       = sclk_q;
    sdi_nxt        = sdi_q;
    nrst_nxt       = nrst_q;
    preq_nxt       = preq_q;
    busy_nxt       = busy_q;
    done_nxt       = done_q;
    terr_nxt       = terr_q;
`ifdef PLL_CFG_READBACK_EN
    cfg_lat_nxt    = cfg_lat;
    rb_nxt         = rb_q;
    verr_nxt       = verr_q;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_HOLD;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          terr_nxt     = 1'b0;
          nrst_nxt     = 1'b0;
          preq_nxt     = 1'b1;
          shreg_nxt    = cfg_data;
          hold_cnt_nxt = '0;
          div_cnt_nxt  = '0;
`ifdef PLL_CFG_READBACK_EN
          cfg_lat_nxt  = cfg_data;
          rb_nxt       = '0;
          verr_nxt     = 1'b0;
`endif
        end
      end

      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = S_SHIFT_LO;
          hold_cnt_nxt = '0;
          div_cnt_nxt  = '0;
          bit_idx_nxt  = BIT_TOP;
          sclk_nxt     = 1'b0;
          sdi_nxt      = shreg[CFG_BITS-1];
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end

      S_SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt   = S_SHIFT_HI;
          div_cnt_nxt = '0;
          sclk_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          // Last high cycle: capture SDO, advance the word, drop SCLK
          div_cnt_nxt = '0;
          sclk_nxt    = 1'b0;
          shreg_nxt   = {shreg[CFG_BITS-2:0], 1'b0};
`ifdef PLL_CFG_READBACK_EN
          rb_nxt      = {rb_q[CFG_BITS-2:0], pll_sdo};
`endif
          if (bit_idx == '0) begin
            state_nxt = S_RELEASE;
            sdi_nxt   = 1'b0;
            nrst_nxt  = 1'b1;
          end else begin
            state_nxt   = S_SHIFT_LO;
            bit_idx_nxt = bit_idx - BIT_W'(1);
            sdi_nxt     = shreg[CFG_BITS-2];
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_RELEASE: begin
        state_nxt      = S_WAIT_LOCK;
        stable_cnt_nxt = '0;
        tmo_cnt_nxt    = '0;
      end

      S_WAIT_LOCK: begin
        // A single low sample of the lock restarts the stability count
        stable_cnt_nxt = locked_s ? (stable_cnt + STABLE_W'(1)) : '0;
        tmo_cnt_nxt    = tmo_cnt + TMO_W'(1);
        // Stable lock is checked first so it wins a same-cycle tie
        if (stable_cnt_nxt == STABLE_TGT) begin
          state_nxt   = S_FINISH;
          lock_ok_nxt = 1'b1;
        end else if (tmo_cnt_nxt == TMO_TGT) begin
          state_nxt   = S_FINISH;
          lock_ok_nxt = 1'b0;
        end
      end

      S_FINISH: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        terr_nxt  = !lock_ok;
        if (lock_ok) begin
          preq_nxt = 1'b0;
        end
`ifdef PLL_CFG_READBACK_EN
        verr_nxt  = (rb_q != cfg_lat);
`endif
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign pll_sclk       = sclk_q;
  assign pll_sdi        = sdi_q;
  assign pll_nreset     = nrst_q;
  assign pclk_reset_req = preq_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = terr_q;

`ifdef PLL_CFG_READBACK_EN
  assign readback       = rb_q;
  assign verify_err     = verr_q;
`else
  assign readback       = '0;
  assign verify_err     = 1'b0;
`endif

endmodule
`default_nettype wire
